delay_scheduler: RTL and testbench
==================================

Name: delay_scheduler

Overview:
- Shares one programmable matched-delay resource between NREQ requesters in the bundled-data pipeline.
- Each requester runs a four-phase req/ack handshake and supplies a delay length in clock cycles.
- The block grants requesters round-robin, times the delay with a down-counter, and returns ack when the delay expires.
- It sits between the pipeline stage controllers and the shared timing resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN_W, 4, width of each delay-length field.
- IDW, 2, width of grant_id; IDW = clog2(NREQ).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  NREQ  four-phase request, one bit per requester.
- len  in  NREQ*LEN_W  delay length. Requester i uses bits [i*LEN_W +: LEN_W]. The value must be held stable while req[i] is high.
- ack  out  NREQ  four-phase acknowledge, one-hot or zero.
- busy  out  1  high in RUN or ACK.
- grant_id  out  IDW  index of the current grantee; holds its value in IDLE.
- err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, ack=0, busy=0, grant_id=0, err=0, cnt=0.
  - Round-robin pointer ptr=0, meaning requester 0 has highest priority.
- States: IDLE, RUN, ACK.
- IDLE:
  - If any req bit is high, select the first set bit searching ptr, ptr+1, ... with wrap modulo NREQ.
  - Next edge: grant_id=selected index, cnt=max(len_sel,1), state=RUN, busy=1.
  - If no req bit is high, stay in IDLE.
- RUN:
  - Each edge: if cnt==1, state=ACK and ack[grant_id]=1; otherwise cnt=cnt-1.
  - Timing: ack goes high exactly L edges after the grant edge, where L=max(len,1). len=0 behaves as len=1.
  - Maximum L is 2^LEN_W-1.
- ACK:
  - ack[grant_id] stays high until req[grant_id] is sampled low.
  - On that edge: ack=0, state=IDLE, busy=0, ptr=(grant_id+1) mod NREQ.
  - The earliest next grant is the following edge, so there is at least one IDLE cycle between grants.
- Protocol violation: req[grant_id] sampled low during RUN.
  - Next edge: state=IDLE, ack stays 0, busy=0, err=1 for exactly one cycle.
  - ptr advances as in a normal completion; the aborted requester gets no ack.
- Simultaneous requests: exactly one grant, chosen by ptr order. Losers wait with req held; no request is lost.
- Requests from non-granted requesters that arrive during RUN/ACK are ignored until IDLE.
- len is sampled only at the grant edge. Changes to len during RUN do not affect cnt.
- ack may only rise in RUN→ACK and may only fall in ACK→IDLE, so ack is glitch-free and registered.
- Asserting rst_n low mid-operation aborts immediately to reset values. No ack is produced after reset release until a new grant.
- Width rules:
  - cnt is LEN_W bits and never underflows; the minimum loaded value is 1.
  - ptr is IDW bits; when NREQ is not a power of two, wrap at NREQ-1→0.

Decomposition:
- Package delay_sched_pkg holds:
  - the state enum (IDLE, RUN, ACK) with 2-bit encoding;
  - localparam constants for the default NREQ and LEN_W.
- Sub-module rr_arbiter:
  - combinational round-robin select;
  - inputs: req vector and ptr;
  - outputs: valid and index;
  - reusable by other shared-resource controllers in the core.
- The top level holds the FSM, counter, ptr and output registers.

Test Plan:
- Single request, L=3: req[1]=1, len1=3 → grant_id=1 at edge E0, ack[1]=1 at E3. Drop req[1] → ack[1]=0 and busy=0 on the next edge.
- len=0: req[0], len0=0 → ack[0] rises 1 edge after the grant, same as len=1.
- Contention and fairness: req=4'b1111 held, all len=2, each requester drops req one cycle after its ack → grant order 0,1,2,3,0. Each cycle of the pattern is 1 IDLE + 2 RUN + ACK cycles.
- Wrap and pointer: after serving 3, req=4'b1001 → requester 0 is granted before 3.
- Violation: req[2]=1, len=5, drop req[2] at RUN cycle 2 → err pulses once, ack[2] never rises, state returns to IDLE, ptr=3.
- Async reset mid-RUN: assert rst_n=0 between clock edges → ack, busy and grant_id become 0 immediately. After release with req held, a fresh grant starts from ptr=0 with full len timing.

Source files
------------

// File: rtl/delay_sched_pkg.sv
// Shared types and default sizing for the matched-delay scheduler.
package delay_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int LEN_W_DEF = 4;

endpackage

// File: rtl/delay_scheduler_rr_arbiter.sv
// Combinational round-robin select: first set request at or after i_ptr,
// wrapping modulo NREQ. Usable by any shared-resource controller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_valid,
  output logic [IDW-1:0]  o_index
);

  // i_ptr is always below NREQ, so a single conditional subtract wraps the sum
  function automatic int wrap(int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  // scan from the lowest priority upward so the last hit is the highest priority
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[wrap(int'(i_ptr) + k)]) begin
        o_valid = 1'b1;
        o_index = IDW'(wrap(int'(i_ptr) + k));
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// Shares one programmable delay timer among NREQ four-phase requesters.
//
//   state | meaning
//   IDLE  | no grantee; arbiter picks next requester in round-robin order
//   RUN   | down-counter timing the grantee's delay (len 0 treated as 1)
//   ACK   | ack held high until the grantee drops req
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   len,
  output logic [NREQ-1:0]         ack,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id,
  output logic                    err
);

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_cnt;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_gid;
  logic [NREQ-1:0]   r_ack;
  logic              r_err;

  logic              w_arb_valid;
  logic [IDW-1:0]    w_arb_idx;
  logic [LEN_W-1:0]  w_len_sel;
  logic [LEN_W-1:0]  w_len_load;
  logic              w_req_gnt;
  logic              w_cnt_last;
  logic [IDW-1:0]    w_ptr_next;
  logic [NREQ-1:0]   w_gnt_onehot;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_arb_valid),
    .o_index (w_arb_idx)
  );

  assign w_len_sel    = len[int'(w_arb_idx)*LEN_W +: LEN_W];
  assign w_len_load   = (w_len_sel == '0) ? LEN_W'(1) : w_len_sel;
  assign w_req_gnt    = req[r_gid];
  assign w_cnt_last   = (r_cnt == LEN_W'(1));
  assign w_ptr_next   = (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
  assign w_gnt_onehot = NREQ'(1) << r_gid;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next-state decode; a grantee dropping req during RUN aborts back to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_arb_valid) w_next = ST_RUN;
      ST_RUN: begin
        if (!w_req_gnt)      w_next = ST_IDLE;
        else if (w_cnt_last) w_next = ST_ACK;
      end
      ST_ACK:  if (!w_req_gnt) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // grant capture, delay counter, round-robin pointer, registered ack/err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ptr <= '0;
      r_gid <= '0;
      r_ack <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_gid <= w_arb_idx;
            r_cnt <= w_len_load;
          end
        end
        ST_RUN: begin
          if (!w_req_gnt) begin
            r_err <= 1'b1;
            r_ptr <= w_ptr_next;
          end else if (w_cnt_last) begin
            r_ack <= w_gnt_onehot;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ACK: begin
          if (!w_req_gnt) begin
            r_ack <= '0;
            r_ptr <= w_ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs are straight from registers
  always_comb begin
    busy     = (r_state != ST_IDLE);
    ack      = r_ack;
    grant_id = r_gid;
    err      = r_err;
  end

endmodule

// File: tb/tb_delay_scheduler.sv
// Scoreboarded bench for delay_scheduler: directed scenarios followed by
// randomized four-phase requesters, checked against a transaction-level model.
module tb_delay_scheduler;

  localparam int NREQ  = 4;
  localparam int LEN_W = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*LEN_W-1:0] len = '0;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  err;

  always #5 clk = ~clk;

  delay_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .len      (len),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .err      (err)
  );

  typedef struct {
    bit is_err;
    int id;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // reference model: one owner at a time, completion time stamped at grant
  int  m_owner = -1;
  int  m_ptr = 0;
  int  m_gid = 0;
  int  m_ack_at = 0;
  bit  m_acked = 1'b0;
  logic [NREQ-1:0] prev_ack = '0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int len_of(int i);
    return int'(len[i*LEN_W +: LEN_W]);
  endfunction

  function automatic int onehot_idx(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
    m_owner = -1;
    m_ptr   = 0;
    m_gid   = 0;
    m_acked = 1'b0;
  end

  always @(posedge clk) begin
    int sel;
    int dly;
    cyc++;
    if (rst_n) begin
      if (m_owner < 0) begin
        if (req != '0) begin
          sel = -1;
          for (int k = 0; k < NREQ; k++)
            if (sel < 0 && req[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
          dly = len_of(sel);
          if (dly == 0) dly = 1;
          m_owner  = sel;
          m_gid    = sel;
          m_ack_at = cyc + dly;
          m_acked  = 1'b0;
          exp_q.push_back('{is_err: 1'b0, id: sel, cyc: cyc + dly});
        end
      end else if (!req[m_owner]) begin
        if (!m_acked) begin
          if (exp_q.size() > 0) void'(exp_q.pop_back());
          exp_q.push_back('{is_err: 1'b1, id: m_owner, cyc: cyc});
        end
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_acked = 1'b0;
      end else if (cyc == m_ack_at) begin
        m_acked = 1'b1;
      end
    end
  end

  task automatic sb_take(bit is_err, int id);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %s id %0d at cycle %0d, expected no event",
               is_err ? "err" : "ack", id, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_err != is_err || e.id != id || e.cyc != cyc) begin
        errors++;
        $display("FAIL sb_event: got %s id %0d cyc %0d, expected %s id %0d cyc %0d",
                 is_err ? "err" : "ack", id, cyc, e.is_err ? "err" : "ack", e.id, e.cyc);
      end
    end
  endtask

  // monitor: pops the scoreboard on each ack rise / err pulse, checks levels every cycle
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ack;
    if (rst_n) begin
      if (err) sb_take(1'b1, int'(grant_id));
      if (ack != '0 && prev_ack == '0) sb_take(1'b0, onehot_idx(ack));
    end
    exp_ack = (m_owner >= 0 && m_acked) ? NREQ'(1) << m_owner : '0;
    chk("mon_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
    chk("mon_grant_id", int'(grant_id), m_gid);
    chk("mon_ack", int'(ack), int'(exp_ack));
    prev_ack = ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int id, output int n);
    n = 0;
    while (ack == '0 && n < 40) begin
      tick();
      n++;
    end
    id = onehot_idx(ack);
  endtask

  task automatic set_len(int i, int v);
    len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  int ph   [NREQ];
  int hold [NREQ];

  initial begin
    int id;
    int n;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_ack", int'(ack), 0);
    chk("reset_grant_id", int'(grant_id), 0);
    chk("reset_err", int'(err), 0);

    // single request, L=3
    set_len(1, 3);
    req[1] = 1'b1;
    tick();
    chk("t1_grant", int'(grant_id), 1);
    chk("t1_busy", int'(busy), 1);
    wait_ack(id, n);
    chk("t1_latency", n, 3);
    chk("t1_ack_id", id, 1);
    req[1] = 1'b0;
    tick();
    chk("t1_ack_fall", int'(ack), 0);
    chk("t1_idle", int'(busy), 0);

    // len=0 behaves as 1
    set_len(0, 0);
    req[0] = 1'b1;
    tick();
    chk("t2_grant", int'(grant_id), 0);
    wait_ack(id, n);
    chk("t2_latency", n, 1);
    req[0] = 1'b0;
    tick();

    // contention from a fresh pointer
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(id, n);
      chk("fair_order", id, k % NREQ);
      chk("fair_period", n, 3);
      if (id >= 0) begin
        req[id] = 1'b0;
        tick();
        chk("fair_ack_fall", int'(ack), 0);
        req[id] = 1'b1;
      end
    end
    req = '0;
    tick();
    tick();

    // serve 3, then 0 must win over 3
    set_len(3, 1);
    set_len(0, 1);
    req = 4'b1000;
    wait_ack(id, n);
    chk("wrap_serve3", id, 3);
    req = '0;
    tick();
    req = 4'b1001;
    tick();
    chk("wrap_grant0", int'(grant_id), 0);
    wait_ack(id, n);
    req[0] = 1'b0;
    tick();
    tick();
    chk("wrap_then3", int'(grant_id), 3);
    wait_ack(id, n);
    req = '0;
    tick();

    // protocol violation: drop req during RUN
    set_len(2, 5);
    req[2] = 1'b1;
    tick();
    chk("viol_grant", int'(grant_id), 2);
    tick();
    req[2] = 1'b0;
    tick();
    chk("viol_err", int'(err), 1);
    chk("viol_busy", int'(busy), 0);
    chk("viol_ack", int'(ack), 0);
    tick();
    chk("viol_err_once", int'(err), 0);
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    req = 4'b1111;
    tick();
    chk("viol_ptr3", int'(grant_id), 3);
    wait_ack(id, n);
    req = '0;
    tick();

    // len is captured only at the grant edge
    set_len(1, 4);
    req[1] = 1'b1;
    tick();
    set_len(1, 1);
    wait_ack(id, n);
    chk("len_sampled", n, 4);
    req[1] = 1'b0;
    tick();

    // async reset mid-RUN, then fresh grant from ptr 0
    set_len(1, 6);
    set_len(3, 6);
    req = 4'b1010;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", int'(ack), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_grant_id", int'(grant_id), 0);
    rst_n = 1'b1;
    tick();
    chk("arst_regrant", int'(grant_id), 1);
    wait_ack(id, n);
    chk("arst_latency", n, 6);
    req = '0;
    tick();
    tick();

    // randomized four-phase requesters
    for (int i = 0; i < NREQ; i++) begin
      ph[i]   = 0;
      hold[i] = 0;
    end
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        case (ph[i])
          0: begin
            set_len(i, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
              req[i] = 1'b1;
              ph[i]  = 1;
            end
          end
          1: begin
            if (ack[i]) begin
              ph[i]   = 2;
              hold[i] = int'($urandom_range(0, 3));
            end else if ($urandom_range(0, 63) == 0) begin
              req[i] = 1'b0;
              ph[i]  = 0;
            end
          end
          2: begin
            if (hold[i] == 0) begin
              req[i] = 1'b0;
              ph[i]  = 3;
            end else begin
              hold[i]--;
            end
          end
          default: if (!ack[i]) ph[i] = 0;
        endcase
      end
      tick();
    end

    req = '0;
    repeat (6) tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
